// File: rtl/console_uart_tx.sv
// Buffered console UART transmitter: a power-of-2 byte FIFO feeding an 8N1 serialiser.
// Define CONSOLE_UART_PARITY_EN to add an even-parity bit, giving 8E1 frames.
module console_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned FIFO_DEPTH   = 16
) (
  input  logic                          CLK,
  input  logic                          RESETN,
  input  logic [7:0]                    CONSOLE_OUT,
  input  logic                          CONSOLE_OUT_valid,
  output logic                          CONSOLE_OUT_ready,
  output logic                          TX,
  output logic                          TX_BUSY,
  output logic [$clog2(FIFO_DEPTH):0]   FIFO_COUNT
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0] TimerLoad = TW'(CLKS_PER_BIT - 1);

`ifdef CONSOLE_UART_PARITY_EN
  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;
`else
  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;
`endif

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  state_e        state_q;
  logic [TW-1:0] timer_q;
  logic [2:0]    bit_idx_q;
  logic [7:0]    shift_q;
  logic          tx_q;
`ifdef CONSOLE_UART_PARITY_EN
  logic          parity_q;
`endif

  logic push, pop, bit_done, fifo_nonempty;

  assign fifo_nonempty = (count_q != '0);
  assign bit_done      = (timer_q == '0);
  assign push          = CONSOLE_OUT_valid && CONSOLE_OUT_ready;
  // Pop only when the shifter is free: idle, or on the last cycle of a stop bit.
  assign pop           = fifo_nonempty &&
                         ((state_q == StIdle) || ((state_q == StStop) && bit_done));

  assign CONSOLE_OUT_ready = (count_q != CW'(FIFO_DEPTH));
  assign TX_BUSY           = (state_q != StIdle) || fifo_nonempty;
  assign FIFO_COUNT        = count_q;
  assign TX                = tx_q;

  always_ff @(posedge CLK) begin
    if (push) mem_q[wr_ptr_q] <= CONSOLE_OUT;
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q   <= StIdle;
      timer_q   <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
`ifdef CONSOLE_UART_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else if (pop) begin
      shift_q   <= mem_q[rd_ptr_q];
      timer_q   <= TimerLoad;
      state_q   <= StStart;
      tx_q      <= 1'b0;
`ifdef CONSOLE_UART_PARITY_EN
      parity_q  <= ^mem_q[rd_ptr_q];
`endif
    end else begin
      case (state_q)
        StIdle: tx_q <= 1'b1;
        StStart: begin
          if (bit_done) begin
            state_q   <= StData;
            timer_q   <= TimerLoad;
            bit_idx_q <= '0;
            tx_q      <= shift_q[0];
          end else begin
            timer_q <= timer_q - TW'(1);
          end
        end
        StData: begin
          if (bit_done) begin
            timer_q <= TimerLoad;
            if (bit_idx_q == 3'd7) begin
`ifdef CONSOLE_UART_PARITY_EN
              state_q <= StParity;
              tx_q    <= parity_q;
`else
              state_q <= StStop;
              tx_q    <= 1'b1;
`endif
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
              shift_q   <= shift_q >> 1;
              tx_q      <= shift_q[1];
            end
          end else begin
            timer_q <= timer_q - TW'(1);
          end
        end
`ifdef CONSOLE_UART_PARITY_EN
        StParity: begin
          if (bit_done) begin
            state_q <= StStop;
            timer_q <= TimerLoad;
            tx_q    <= 1'b1;
          end else begin
            timer_q <= timer_q - TW'(1);
          end
        end
`endif
        StStop: begin
          if (bit_done) begin
            state_q <= StIdle;
            tx_q    <= 1'b1;
          end else begin
            timer_q <= timer_q - TW'(1);
          end
        end
        default: begin
          state_q <= StIdle;
          tx_q    <= 1'b1;
        end
      endcase
    end
  end

endmodule
